serial_subtractor: RTL and testbench

Bit-serial, multi-cycle N-bit subtractor computing Diff = A - B - Bin. It processes one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the subtracting counterpart to the datapath's carry-chain adder, trading latency for area. A start/ready/done handshake lets a controller issue operations back to back.

---
 rtl/serial_subtractor_pkg.sv | 24 ++
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   sub_state_t   : controller states (IDLE, RUN, DONE)
//   SUB_MIN_WIDTH : smallest legal operand width
//   SUB_MAX_WIDTH : largest legal operand width
//   signed_ovf()  : two's-complement overflow rule for A - (B + Bin)
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_MIN_WIDTH = 2;
    localparam int SUB_MAX_WIDTH = 32;

    // Overflow is only possible when the operands have opposite signs; it
    // happened when the result sign differs from the minuend sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the serial subtractor.
//   start/A/B/Bin        : request and operands (controller -> subtractor)
//   ready/busy/done      : status (subtractor -> controller)
//   Diff/Bout/Ovf        : registered result (subtractor -> controller)
// Modports: master = controller side, slave = subtractor side.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    modport master (
        output start, A, B, Bin,
        input  ready, busy, done, Diff, Bout, Ovf
    );

    modport slave (
        input  start, A, B, Bin,
        output ready, busy, done, Diff, Bout, Ovf
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin.
//   a, b, bin : operand bits and incoming borrow
//   diff      : difference bit
//   bout      : outgoing borrow
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor computing Diff = A - B - Bin, LSB first, one
// bit per clock through a single full_subtractor cell.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_subtractor_if.slave (start/A/B/Bin in; ready/busy/done,
//         Diff/Bout/Ovf out). Result valid while done pulses, held after.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    generate
        if (WIDTH < SUB_MIN_WIDTH || WIDTH > SUB_MAX_WIDTH) begin : g_bad_width
            $error("serial_subtractor: WIDTH out of legal range");
        end
    endgenerate

    sub_state_t       state_r;
    sub_state_t       state_n;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             load_s;
    logic             last_s;
    logic             fs_diff_s;
    logic             fs_bout_s;
    logic [WIDTH-1:0] res_shift_s;

    full_subtractor u_fs (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (br_r),
        .diff (fs_diff_s),
        .bout (fs_bout_s)
    );

    // Result bits enter at the MSB so the LSB-first stream lands in place.
    assign res_shift_s = {fs_diff_s, res_r[WIDTH-1:1]};
    assign last_s      = (state_r == RUN) && (cnt_r == LAST_BIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode; DONE accepts a new start for zero-bubble chaining.
    always_comb begin
        state_n = state_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    load_s  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_BIT) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    load_s  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath: operand load, per-bit shift, and result capture on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            diff_r  <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (state_n == RUN);
            done_r <= (state_n == DONE);
            if (load_s) begin
                a_sh_r  <= bus.A;
                b_sh_r  <= bus.B;
                br_r    <= bus.Bin;
                cnt_r   <= {CW{1'b0}};
                a_msb_r <= bus.A[WIDTH-1];
                b_msb_r <= bus.B[WIDTH-1];
            end else if (state_r == RUN) begin
                a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                br_r   <= fs_bout_s;
                res_r  <= res_shift_s;
                cnt_r  <= last_s ? {CW{1'b0}} : (cnt_r + {{(CW-1){1'b0}}, 1'b1});
            end
            if (last_s) begin
                diff_r <= res_shift_s;
                bout_r <= fs_bout_s;
                ovf_r  <= signed_ovf(a_msb_r, b_msb_r, fs_diff_s);
            end
        end
    end

    assign bus.ready = (state_r != RUN);
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.Diff  = diff_r;
    assign bus.Bout  = bout_r;
    assign bus.Ovf   = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases plus
// randomized operations compared against an integer-arithmetic model.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    serial_subtractor_if #(.WIDTH(WIDTH)) sub_if ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sub_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic bin);
        int ua, ub, sa, sb, r, sr;
        logic [3:0] d;
        logic bo, ov;
        ua = int'(a);
        ub = int'(b);
        r  = ua - ub - int'(bin);
        d  = 4'(r & 15);
        bo = (ua < ub + int'(bin));
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        sr = sa - sb - int'(bin);
        ov = (sr < -8) || (sr > 7);
        return {ov, bo, d};
    endfunction

    // Wait up to a bounded number of cycles for done; returns cycles waited.
    task automatic wait_done(output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
            if (sub_if.done) seen = 1'b1;
        end
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [5:0] exp_v;
        int lat;
        exp_v = model(a, b, bin);
        @(negedge clk);
        sub_if.start = 1'b1;
        sub_if.A     = a;
        sub_if.B     = b;
        sub_if.Bin   = bin;
        @(posedge clk);
        #1;
        sub_if.start = 1'b0;
        check("run_busy", 32'(sub_if.busy), 32'd1);
        check("run_ready", 32'(sub_if.ready), 32'd0);
        wait_done(lat);
        check("latency", 32'(lat), 32'(WIDTH));
        check("diff", 32'(sub_if.Diff), 32'(exp_v[3:0]));
        check("bout", 32'(sub_if.Bout), 32'(exp_v[4]));
        check("ovf", 32'(sub_if.Ovf), 32'(exp_v[5]));
        check("done_ready", 32'(sub_if.ready), 32'd1);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(sub_if.done), 32'd0);
        check("idle_ready", 32'(sub_if.ready), 32'd1);
        check("hold_diff", 32'(sub_if.Diff), 32'(exp_v[3:0]));
    endtask

    initial begin
        int lat;
        int ndone;
        errors = 0;
        checks = 0;
        rst          = 1'b1;
        sub_if.start = 1'b0;
        sub_if.A     = 4'd0;
        sub_if.B     = 4'd0;
        sub_if.Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(sub_if.ready), 32'd1);
        check("rst_busy", 32'(sub_if.busy), 32'd0);
        check("rst_done", 32'(sub_if.done), 32'd0);
        check("rst_diff", 32'(sub_if.Diff), 32'd0);
        check("rst_bout", 32'(sub_if.Bout), 32'd0);
        check("rst_ovf", 32'(sub_if.Ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-computed results.
        do_op(4'd7, 4'd3, 1'b0);
        check("t1_diff", 32'(sub_if.Diff), 32'h4);
        check("t1_bout", 32'(sub_if.Bout), 32'd0);
        do_op(4'd3, 4'd7, 1'b0);
        check("t2_diff", 32'(sub_if.Diff), 32'hC);
        check("t2_bout", 32'(sub_if.Bout), 32'd1);
        do_op(4'd0, 4'd0, 1'b1);
        check("t3_diff", 32'(sub_if.Diff), 32'hF);
        check("t3_bout", 32'(sub_if.Bout), 32'd1);
        check("t3_ovf", 32'(sub_if.Ovf), 32'd0);
        do_op(4'd7, 4'hF, 1'b0);
        check("t4_diff", 32'(sub_if.Diff), 32'h8);
        check("t4_ovf", 32'(sub_if.Ovf), 32'd1);
        do_op(4'd8, 4'd1, 1'b0);
        check("t5_diff", 32'(sub_if.Diff), 32'h7);
        check("t5_bout", 32'(sub_if.Bout), 32'd0);
        check("t5_ovf", 32'(sub_if.Ovf), 32'd1);

        // start while busy must be ignored.
        @(negedge clk);
        sub_if.start = 1'b1;
        sub_if.A     = 4'd9;
        sub_if.B     = 4'd2;
        sub_if.Bin   = 1'b0;
        @(posedge clk);
        #1;
        sub_if.start = 1'b0;
        @(posedge clk);
        #1;
        sub_if.start = 1'b1;
        sub_if.A     = 4'd1;
        sub_if.B     = 4'd1;
        @(posedge clk);
        #1;
        sub_if.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (sub_if.done) begin
                ndone++;
                check("busy_ign_diff", 32'(sub_if.Diff), 32'h7);
                check("busy_ign_bout", 32'(sub_if.Bout), 32'd0);
            end
        end
        check("busy_ign_ndone", 32'(ndone), 32'd1);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        sub_if.start = 1'b1;
        sub_if.A     = 4'd9;
        sub_if.B     = 4'd4;
        @(posedge clk);
        #1;
        sub_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_diff", 32'(sub_if.Diff), 32'd0);
        check("arst_bout", 32'(sub_if.Bout), 32'd0);
        check("arst_ovf", 32'(sub_if.Ovf), 32'd0);
        check("arst_ready", 32'(sub_if.ready), 32'd1);
        check("arst_busy", 32'(sub_if.busy), 32'd0);
        check("arst_done", 32'(sub_if.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (sub_if.done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        do_op(4'd5, 4'd5, 1'b0);
        check("post_rst_diff", 32'(sub_if.Diff), 32'd0);
        check("post_rst_bout", 32'(sub_if.Bout), 32'd0);

        // Back-to-back: new start presented in the DONE cycle.
        @(negedge clk);
        sub_if.start = 1'b1;
        sub_if.A     = 4'd6;
        sub_if.B     = 4'd1;
        sub_if.Bin   = 1'b0;
        @(posedge clk);
        #1;
        sub_if.start = 1'b0;
        wait_done(lat);
        check("b2b_lat1", 32'(lat), 32'(WIDTH));
        check("b2b_diff1", 32'(sub_if.Diff), 32'h5);
        sub_if.start = 1'b1;
        sub_if.A     = 4'd2;
        sub_if.B     = 4'd3;
        @(posedge clk);
        #1;
        sub_if.start = 1'b0;
        check("b2b_busy", 32'(sub_if.busy), 32'd1);
        check("b2b_hold", 32'(sub_if.Diff), 32'h5);
        wait_done(lat);
        check("b2b_lat2", 32'(lat), 32'(WIDTH));
        check("b2b_diff2", 32'(sub_if.Diff), 32'hF);
        check("b2b_bout2", 32'(sub_if.Bout), 32'd1);
        @(posedge clk);
        #1;

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            do_op(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                  1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
